// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants used by fetch, decode and the PC logic.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  // Byte distance between consecutive sequential instructions.
  localparam int unsigned PC_STEP = ILEN / 8;

endpackage

// File: rtl/riscv_fifo.sv
// Power-of-two synchronous FIFO with flush; head data is read combinationally.
module riscv_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  // NOTE: non-blocking assignments keep every register update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/riscv_if_fetch.sv
// Instruction fetch stage: credit-limited in-order requests, PC tag tracking,
// redirect flush with stale-response discard, and a decode-facing queue.
module riscv_if_fetch #(
  parameter int unsigned     XLEN     = riscv_pkg::XLEN,
  parameter int unsigned     ILEN     = riscv_pkg::ILEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC),
  parameter int unsigned     QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr
);

  localparam int unsigned     STEP       = ILEN / 8;
  localparam int unsigned     CW         = $clog2(QDEPTH) + 1;
  localparam logic [XLEN-1:0] STEP_W     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(STEP - 1);
  localparam logic [CW:0]     CREDITS    = (CW+1)'(QDEPTH);

  logic [XLEN-1:0]      fetch_pc;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        discard;
  logic [CW:0]          credit_used;
  logic                 req_fire;
  logic                 rsp_take;
  logic                 rsp_keep;
  logic                 q_pop;
  logic [XLEN-1:0]      tag_pc;
  logic [XLEN+ILEN-1:0] q_head;
  logic                 q_full, q_empty, tag_full, tag_empty;
  logic [CW-1:0]        q_count, tag_count;

  // Discarded fetches still hold tag slots, so they count against the credit.
  assign credit_used    = {1'b0, q_count} + {1'b0, outstanding} + {1'b0, discard};
  assign imem_req_valid = rst && !redirect && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (outstanding != '0 || discard != '0);
  assign rsp_keep       = rsp_take && (discard == '0) && !redirect;
  assign q_pop          = !q_empty && !bubble && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc & ALIGN_MASK;
      outstanding <= '0;
      discard     <= discard + outstanding + CW'(req_fire) - CW'(rsp_take);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP_W;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take && discard == '0);
      discard     <= discard - CW'(rsp_take && discard != '0);
    end
  end

  riscv_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_take),
    .flush (1'b0),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  riscv_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(QDEPTH)) u_instr_q (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (q_pop),
    .flush (redirect),
    .wdata ({tag_pc, imem_rsp_data}),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign out_valid = !q_empty;
  assign out_pc    = out_valid ? q_head[XLEN+ILEN-1:ILEN] : '0;
  assign out_instr = out_valid ? q_head[ILEN-1:0] : '0;

  a_rsp_protocol: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && outstanding == '0 && discard == '0));
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(req_fire && tag_full));
  a_q_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_keep && q_full));
  a_tag_tracks: assert property (@(posedge clk) disable iff (!rst)
    (tag_count == outstanding + discard) && (tag_empty == (tag_count == '0)));

endmodule

// File: tb/tb_riscv_if_fetch.sv
// Randomised scoreboard bench for riscv_if_fetch plus a wrap-around instance.
module tb_riscv_if_fetch;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bubble, redirect, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_pc, out_instr;

  logic        w_req_valid, w_rsp_valid, w_out_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_out_pc, w_out_instr;

  always #5 clk = ~clk;

  riscv_if_fetch #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .QDEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .bubble(bubble), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr)
  );

  riscv_if_fetch #(.XLEN(32), .ILEN(32), .RESET_PC(WRAP_PC), .QDEPTH(4)) u_wrap (
    .clk(clk), .rst(rst), .bubble(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data), .out_valid(w_out_valid),
    .out_pc(w_out_pc), .out_instr(w_out_instr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc | 32'hA000_0000;
  endfunction

  // Reference model: after each reset/redirect decode must see base, base+4, ...
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_addr;
  int          consumed = 0;

  task automatic restart(input logic [31:0] pc);
    logic [31:0] base;
    base = pc & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(4 * i));
    exp_req_addr = base;
  endtask

  // Memory model: in-order responses after a per-request latency.
  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  mem_req_t mem_q[$];
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;

  always @(posedge clk) begin
    if (rst && imem_req_valid && imem_req_ready) begin
      int d;
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d < last_due) d = last_due;
      last_due = d;
      mem_q.push_back('{imem_req_addr, d});
    end
    cyc++;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= '0;
    end else begin
      w_rsp_valid <= w_req_valid;
      w_rsp_data  <= instr_of(w_req_addr);
    end
  end

  task automatic drive(input logic b, input logic r, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    bubble = b;
    redirect = r;
    redirect_pc = rpc;
    imem_req_ready = rdy;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
      mem_q.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    if (r) restart(rpc);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_wrap_valid", 32'(w_out_valid), 32'd0);
  endtask

  // Monitor: compares every consumed head and every accepted request address.
  logic        prev_ok = 1'b0;
  logic        p_hold, p_stall;
  logic [31:0] p_out_pc, p_out_instr, p_req_addr, e_pc;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && p_hold) begin
        check("bubble_hold_valid", 32'(out_valid), 32'd1);
        check("bubble_hold_pc", out_pc, p_out_pc);
        check("bubble_hold_instr", out_instr, p_out_instr);
      end
      if (prev_ok && p_stall && !redirect) begin
        check("stall_req_valid", 32'(imem_req_valid), 32'd1);
        check("stall_req_addr", imem_req_addr, p_req_addr);
      end
      if (redirect) begin
        check("redirect_req_valid", 32'(imem_req_valid), 32'd0);
      end else if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_addr);
        exp_req_addr += 32'd4;
      end
      if (out_valid && !bubble && !redirect) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          e_pc = exp_q.pop_front();
          check("out_pc", out_pc, e_pc);
          check("out_instr", out_instr, instr_of(e_pc));
          consumed++;
        end
      end
      p_hold      = out_valid && bubble && !redirect;
      p_stall     = imem_req_valid && !imem_req_ready && !redirect;
      p_out_pc    = out_pc;
      p_out_instr = out_instr;
      p_req_addr  = imem_req_addr;
      prev_ok     = 1'b1;
    end
  end

  // Wrap instance never stalls, so its output stream is simply sequential.
  logic [31:0] w_exp = WRAP_PC;

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      w_exp = WRAP_PC;
    end else if (w_out_valid) begin
      check("wrap_pc", w_out_pc, w_exp);
      check("wrap_instr", w_out_instr, instr_of(w_exp));
      w_exp += 32'd4;
    end
  end

  initial begin
    bubble = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    restart(32'h0);
    #1 rst = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Sequential fetch, then a long bubble that must exhaust the credits.
    repeat (20) drive(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (10) drive(1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    check("credit_stop_req_valid", 32'(imem_req_valid), 32'd0);
    check("credit_stop_out_valid", 32'(out_valid), 32'd1);
    repeat (10) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirects with several fetches in flight, including an unaligned target.
    lat_min = 3;
    lat_max = 3;
    repeat (8) drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 1'b1, 32'h103, 1'b1);
    drive(1'b0, 1'b1, 32'h200, 1'b1);
    drive(1'b0, 1'b1, 32'h103, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Memory stall.
    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (10) drive(1'b0, 1'b0, 32'h0, 1'b1);

    lat_min = 1;
    lat_max = 4;
    repeat (1500)
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) != 0));

    // Asynchronous reset mid-stream.
    @(negedge clk);
    #3;
    rst = 1'b0;
    mem_q.delete();
    last_due = 0;
    imem_rsp_valid = 1'b0;
    redirect = 1'b0;
    bubble = 1'b0;
    imem_req_ready = 1'b1;
    restart(32'h0);
    #1 check_reset_outputs();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    repeat (800)
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom,
            ($urandom_range(0, 3) != 0));
    repeat (5) drive(1'b0, 1'b0, 32'h0, 1'b1);

    check("progress", 32'(consumed > 500), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
